// File: rtl/fp_mul_operand_queue_if.sv
// Handshake bundle between operand producer, the operand queue and the FP multiplier.
// The slave modport is the queue's view; master is the surrounding environment.
interface fp_mul_operand_queue_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_a;
  logic [N-1:0]  out_b;
  logic [2:0]    out_cls_a;
  logic [2:0]    out_cls_b;
  logic          out_special;
  logic [CW-1:0] count;

  modport master (
    output flush, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cls_a, out_cls_b, out_special, count
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cls_a, out_cls_b, out_special, count
  );
endinterface

// File: rtl/fp_mul_operand_queue.sv
// Show-ahead operand FIFO feeding the FP multiplier; each operand is classified
// (normal/zero/inf/NaN/subnormal) at enqueue and the tag travels with the entry.
module fp_mul_operand_queue #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  fp_mul_operand_queue_if.slave  bus
);
  localparam int unsigned M  = (N == 64) ? 52 : 23;
  localparam int unsigned E  = N - 1 - M;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] ClsNormal = 3'b000;
  localparam logic [2:0] ClsZero   = 3'b001;
  localparam logic [2:0] ClsInf    = 3'b010;
  localparam logic [2:0] ClsNan    = 3'b011;
  localparam logic [2:0] ClsSub    = 3'b100;

  function automatic logic [2:0] classify(input logic [N-1:0] x);
    logic [E-1:0] ex;
    logic [M-1:0] ma;
    ex = x[N-2:M];
    ma = x[M-1:0];
    if (ex == '0) begin
      return (ma == '0) ? ClsZero : ClsSub;
    end else if (&ex) begin
      return (ma == '0) ? ClsInf : ClsNan;
    end
    return ClsNormal;
  endfunction

  logic [N-1:0]  mem_a_q   [DEPTH];
  logic [N-1:0]  mem_b_q   [DEPTH];
  logic [2:0]    mem_ca_q  [DEPTH];
  logic [2:0]    mem_cb_q  [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;

  logic       push;
  logic       pop;
  logic [2:0] in_cls_a;
  logic [2:0] in_cls_b;

  always_comb begin
    in_cls_a = classify(bus.in_a);
    in_cls_b = classify(bus.in_b);
  end

  assign bus.in_ready  = (cnt_q != CW'(DEPTH));
  assign bus.out_valid = (cnt_q != '0);
  assign bus.count     = cnt_q;
  assign bus.out_a     = mem_a_q[rd_ptr_q];
  assign bus.out_b     = mem_b_q[rd_ptr_q];
  assign bus.out_cls_a = mem_ca_q[rd_ptr_q];
  assign bus.out_cls_b = mem_cb_q[rd_ptr_q];
  assign bus.out_special = bus.out_valid &&
                           (mem_ca_q[rd_ptr_q] != ClsNormal || mem_cb_q[rd_ptr_q] != ClsNormal);

  // in_ready is derived from count alone, so a full queue refuses a push even on a pop cycle.
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_a_q[i]  <= '0;
        mem_b_q[i]  <= '0;
        mem_ca_q[i] <= '0;
        mem_cb_q[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_a_q[wr_ptr_q]  <= bus.in_a;
        mem_b_q[wr_ptr_q]  <= bus.in_b;
        mem_ca_q[wr_ptr_q] <= in_cls_a;
        mem_cb_q[wr_ptr_q] <= in_cls_b;
        wr_ptr_q           <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end
endmodule

// File: doc/fp_mul_operand_queue.md
Name: fp_mul_operand_queue

Overview:
- Buffered operand-issue stage directly upstream of the FP multiplier.
- Accepts (A, B) operand pairs over a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Classifies each operand at enqueue time (normal/zero/inf/NaN/subnormal) and presents the head pair plus its class tags to the multiplier. The multiplier can then select its special-case path without re-decoding the operands.

Parameters:
N, 32, operand width; legal values 32 (E=8, M=23) or 64 (E=11, M=52)
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous queue clear
in_valid  input  1  operand pair offered
in_ready  output  1  queue can accept
in_a  input  N  operand A
in_b  input  N  operand B
out_valid  output  1  head entry valid
out_ready  input  1  multiplier consumes head
out_a  output  N  head operand A
out_b  output  N  head operand B
out_cls_a  output  3  class of out_a
out_cls_b  output  3  class of out_b
out_special  output  1  either head operand class != normal
count  output  clog2(DEPTH)+1  occupancy

Behaviour:
- Field split: sign=[N-1]; exp=[N-2:M]; mant=[M-1:0]; M=23/E=8 for N=32, M=52/E=11 for N=64.
- Class encoding:
  - 000 normal: exp not all-0, not all-1.
  - 001 zero: exp=0 and mant=0; either sign.
  - 010 inf: exp all-1 and mant=0; either sign.
  - 011 NaN: exp all-1 and mant!=0.
  - 100 subnormal: exp=0 and mant!=0.
  - 101-111: never produced.
- Classification is combinational on in_a/in_b. It is stored with the entry at the push edge and is never recomputed.
- Push: occurs when in_valid && in_ready && !flush. Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready && !flush. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH).
  - No full-bypass: when full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_a, out_b, out_cls_a, out_cls_b always reflect mem[rd_ptr] (show-ahead). They are stable while out_valid && !out_ready.
- out_special = out_valid && (out_cls_a!=000 || out_cls_b!=000).
- Latency: pair pushed at edge t is visible at the outputs after edge t when the queue was empty (1 cycle); no zero-cycle combinational bypass.
- Count update per edge:
  - push and pop together: count unchanged; both pointers advance.
  - push only: count +1.
  - pop only: count -1.
- Pointers wrap DEPTH-1 -> 0; a wr_ptr==rd_ptr ambiguity is resolved by count.
- Pop when empty is impossible because out_valid=0. Push when full is impossible because in_ready=0.
- in_valid may drop without a handshake. Upstream holds data while in_valid && !in_ready.
- flush: at the edge, count=0 and wr_ptr=rd_ptr=0. It overrides a simultaneous push or pop; that push is dropped. in_ready is 1 on the next cycle.
- Reset (async, any time, including mid-transfer):
  - count=0, both pointers=0, all mem entries and class tags=0.
  - Therefore out_a=out_b=0, out_cls=000, out_valid=0, out_special=0, in_ready=1.
  - Operation resumes on the first edge after rst deasserts.
- Special-value handling (signs, NaN payloads) is left entirely to the downstream multiplier. The queue passes operand bits unmodified.

Test Plan:
- Reset, then push A=32'h3F800000, B=32'h40000000 -> out_valid=1 one cycle later; out_a/out_b match; cls 000/000; out_special=0; count=1.
- Push A=32'h80000000, B=32'h7F800000; then push A=32'h7FC00000, B=32'h00000001 -> head cls 001/010, special=1. After the pop, head cls 011/100.
- Hold out_ready=0 and push 4 pairs -> count=4, in_ready=0. A 5th in_valid is not accepted and its data is never seen. Drain -> order preserved, count returns to 0, out_valid=0.
- At count=2, push and pop together for 10 cycles with incrementing data -> count stays 2, pointers wrap, every pair is delivered in order exactly once.
- With 3 entries queued, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle pair never appears.
- N=64: push A=64'h7FF0000000000000, B=64'h0000000000000000 -> cls 010/001. Assert rst asynchronously mid-stream -> outputs go to reset values immediately, without waiting for a clock edge.
